// File: rtl/dma_pkg.sv
// Shared types and helpers for the single-channel DMA sequencer.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LAUNCH,
    ST_RUN,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ZERO_LEN = 3'd1;
  localparam logic [2:0] ERR_MISALIGN = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_ABORT    = 3'd4;

  function automatic logic [31:0] chunk_min(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dma_timeout_cnt.sv
// Loadable down-counter; expire flags the last enabled cycle before reaching zero.
module dma_timeout_cnt #(
  parameter int unsigned C_LOAD = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(C_LOAD + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(C_LOAD);
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  // A reload in the same cycle (a done pulse) always beats expiry.
  assign expire = en && !load && (count <= CW'(1));

endmodule

// File: rtl/dma_chan_ctrl.sv
// Single-channel DMA sequencer: validates a descriptor, splits it into FIFO-sized
// chunks and runs Read_Master/Write_Master together for each chunk.
module dma_chan_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH  = 32,
  parameter int unsigned C_CHUNK_BYTES = 4096,
  parameter int unsigned C_TIMEOUT     = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_irq_clr,
  input  logic [C_ADDR_WIDTH-1:0] i_src_addr,
  input  logic [C_ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [31:0]             i_total_len,
  output logic                    o_rd_start,
  output logic [C_ADDR_WIDTH-1:0] o_rd_src_addr,
  output logic [31:0]             o_rd_total_len,
  input  logic                    i_rd_done,
  output logic                    o_wr_start,
  output logic [C_ADDR_WIDTH-1:0] o_wr_dst_addr,
  output logic [31:0]             o_wr_total_len,
  input  logic                    i_wr_done,
  output logic                    o_busy,
  output logic                    o_irq,
  output logic [2:0]              o_err_code,
  output logic [31:0]             o_bytes_done
);

  state_t state, next_state;

  logic [C_ADDR_WIDTH-1:0] cur_src, cur_dst, src_after, dst_after, launch_src, launch_dst;
  logic [C_ADDR_WIDTH-1:0] chunk_src, chunk_dst;
  logic [31:0]             rem, rem_after, launch_rem, chunk_len, bytes_done;
  logic                    rd_seen, wr_seen, rd_hit, wr_hit, abort_pend;
  logic                    busy, irq;
  logic [2:0]              err_code, err_sel;
  logic                    tmo_load, tmo_en, tmo_expire;

  assign rd_hit    = rd_seen | i_rd_done;
  assign wr_hit    = wr_seen | i_wr_done;
  assign rem_after = rem - chunk_len;
  assign src_after = cur_src + C_ADDR_WIDTH'(chunk_len);
  assign dst_after = cur_dst + C_ADDR_WIDTH'(chunk_len);

  // Chunk registers are loaded on entry to LAUNCH so the start pulse and its
  // address/length appear in the same cycle; from NEXT that uses post-advance values.
  assign launch_rem = (state == ST_NEXT) ? rem_after : rem;
  assign launch_src = (state == ST_NEXT) ? src_after : cur_src;
  assign launch_dst = (state == ST_NEXT) ? dst_after : cur_dst;

  assign tmo_load = (state == ST_LAUNCH) || ((state == ST_RUN) && (i_rd_done || i_wr_done));
  assign tmo_en   = (state == ST_RUN);

  dma_timeout_cnt #(
    .C_LOAD(C_TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .load  (tmo_load),
    .en    (tmo_en),
    .expire(tmo_expire)
  );

  always_comb begin
    next_state = state;
    err_sel    = ERR_NONE;
    case (state)
      ST_IDLE:   if (i_start) next_state = ST_CHECK;
      ST_CHECK: begin
        if (rem == '0) begin
          next_state = ST_ERR;
          err_sel    = ERR_ZERO_LEN;
        end else if ((cur_src[1:0] != 2'b00) || (cur_dst[1:0] != 2'b00) ||
                     (rem[1:0] != 2'b00)) begin
          next_state = ST_ERR;
          err_sel    = ERR_MISALIGN;
        end else begin
          next_state = ST_LAUNCH;
        end
      end
      ST_LAUNCH: next_state = ST_RUN;
      ST_RUN: begin
        if (rd_hit && wr_hit) begin
          next_state = ST_NEXT;
        end else if (tmo_expire) begin
          next_state = ST_ERR;
          err_sel    = ERR_TIMEOUT;
        end
      end
      ST_NEXT: begin
        if (abort_pend) begin
          next_state = ST_ERR;
          err_sel    = ERR_ABORT;
        end else if (rem_after == '0) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_LAUNCH;
        end
      end
      ST_DONE:   next_state = ST_IDLE;
      ST_ERR:    next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_src    <= '0;
      cur_dst    <= '0;
      rem        <= '0;
      chunk_src  <= '0;
      chunk_dst  <= '0;
      chunk_len  <= '0;
      bytes_done <= '0;
      rd_seen    <= 1'b0;
      wr_seen    <= 1'b0;
      abort_pend <= 1'b0;
      busy       <= 1'b0;
      irq        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state <= next_state;

      if ((state == ST_IDLE) && i_start) begin
        cur_src    <= i_src_addr;
        cur_dst    <= i_dst_addr;
        rem        <= i_total_len;
        bytes_done <= '0;
        busy       <= 1'b1;
      end

      if (next_state == ST_LAUNCH) begin
        chunk_len <= chunk_min(launch_rem, 32'(C_CHUNK_BYTES));
        chunk_src <= launch_src;
        chunk_dst <= launch_dst;
      end

      if (state == ST_LAUNCH) begin
        rd_seen <= 1'b0;
        wr_seen <= 1'b0;
      end else if (state == ST_RUN) begin
        if (i_rd_done) rd_seen <= 1'b1;
        if (i_wr_done) wr_seen <= 1'b1;
      end

      if (state == ST_NEXT) begin
        rem        <= rem_after;
        cur_src    <= src_after;
        cur_dst    <= dst_after;
        bytes_done <= bytes_done + chunk_len;
      end

      if (next_state == ST_IDLE) begin
        abort_pend <= 1'b0;
      end else if ((state != ST_IDLE) && i_abort) begin
        abort_pend <= 1'b1;
      end

      if ((state == ST_DONE) || (state == ST_ERR)) begin
        busy <= 1'b0;
      end

      if ((next_state == ST_DONE) || (next_state == ST_ERR)) begin
        irq      <= 1'b1;
        err_code <= err_sel;
      end else if (i_irq_clr) begin
        irq      <= 1'b0;
        err_code <= ERR_NONE;
      end
    end
  end

  assign o_rd_start     = (state == ST_LAUNCH);
  assign o_wr_start     = (state == ST_LAUNCH);
  assign o_rd_src_addr  = chunk_src;
  assign o_wr_dst_addr  = chunk_dst;
  assign o_rd_total_len = chunk_len;
  assign o_wr_total_len = chunk_len;
  assign o_busy         = busy;
  assign o_irq          = irq;
  assign o_err_code     = err_code;
  assign o_bytes_done   = bytes_done;

endmodule

// File: tb/tb_dma_chan_ctrl.sv
// Self-checking bench for dma_chan_ctrl with behavioural read/write master responders.
module tb_dma_chan_ctrl;

  localparam int unsigned TMO   = 100;
  localparam int unsigned CHUNK = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_abort, i_irq_clr;
  logic [31:0] i_src_addr, i_dst_addr, i_total_len;
  logic        o_rd_start, o_wr_start, i_rd_done, i_wr_done;
  logic [31:0] o_rd_src_addr, o_rd_total_len, o_wr_dst_addr, o_wr_total_len;
  logic        o_busy, o_irq;
  logic [2:0]  o_err_code;
  logic [31:0] o_bytes_done;

  dma_chan_ctrl #(
    .C_ADDR_WIDTH (32),
    .C_CHUNK_BYTES(CHUNK),
    .C_TIMEOUT    (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_irq_clr     (i_irq_clr),
    .i_src_addr    (i_src_addr),
    .i_dst_addr    (i_dst_addr),
    .i_total_len   (i_total_len),
    .o_rd_start    (o_rd_start),
    .o_rd_src_addr (o_rd_src_addr),
    .o_rd_total_len(o_rd_total_len),
    .i_rd_done     (i_rd_done),
    .o_wr_start    (o_wr_start),
    .o_wr_dst_addr (o_wr_dst_addr),
    .o_wr_total_len(o_wr_total_len),
    .i_wr_done     (i_wr_done),
    .o_busy        (o_busy),
    .o_irq         (o_irq),
    .o_err_code    (o_err_code),
    .o_bytes_done  (o_bytes_done)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic        rd, wr;
    logic [31:0] src, dst, rlen, wlen;
    int unsigned cyc;
  } start_t;

  typedef struct {
    logic [31:0] src, dst, len;
  } chunk_t;

  start_t      obs[$];
  chunk_t      exp_q[$];
  logic [2:0]  exp_err;
  logic [31:0] exp_bytes;
  int unsigned rd_lat, wr_lat, rd_cnt, wr_cnt, last_done;
  int unsigned vectors = 0, miscompares = 0;
  int unsigned c0, irq_cyc;
  bit          timed_out;
  logic        busy_at1;

  // Master responders: each start pulse arms a done pulse 'lat' cycles later (0 = never).
  initial begin
    i_rd_done = 1'b0;
    i_wr_done = 1'b0;
    rd_cnt    = 0;
    wr_cnt    = 0;
    last_done = 0;
    forever begin
      @(negedge clk);
      i_rd_done = 1'b0;
      i_wr_done = 1'b0;
      if (rd_cnt != 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin i_rd_done = 1'b1; last_done = cycle; end
      end
      if (wr_cnt != 0) begin
        wr_cnt--;
        if (wr_cnt == 0) begin i_wr_done = 1'b1; last_done = cycle; end
      end
      if (o_rd_start || o_wr_start) begin
        obs.push_back('{o_rd_start, o_wr_start, o_rd_src_addr, o_wr_dst_addr,
                        o_rd_total_len, o_wr_total_len, cycle});
        if (o_rd_start) rd_cnt = rd_lat;
        if (o_wr_start) wr_cnt = wr_lat;
      end
    end
  end

  // Reference: expected chunk list, error code and byte count from the descriptor alone.
  task automatic model(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                       input int unsigned abort_after);
    logic [31:0] rem, s, d;
    int unsigned n;
    chunk_t      c;
    exp_q.delete();
    exp_bytes = 0;
    exp_err   = 3'd0;
    if (len == 0) begin exp_err = 3'd1; return; end
    if ((src % 4) != 0 || (dst % 4) != 0 || (len % 4) != 0) begin exp_err = 3'd2; return; end
    rem = len; s = src; d = dst; n = 0;
    while (rem != 0) begin
      c.len = (rem > CHUNK) ? CHUNK : rem;
      c.src = s;
      c.dst = d;
      exp_q.push_back(c);
      rem       = rem - c.len;
      s         = s + c.len;
      d         = d + c.len;
      exp_bytes = exp_bytes + c.len;
      n++;
      if (n == abort_after) begin exp_err = 3'd4; return; end
    end
  endtask

  // Drives one descriptor and waits (bounded) for irq; no checking here.
  task automatic do_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                         input int unsigned rl, input int unsigned wl,
                         input int unsigned abort_at, input int unsigned spur_at);
    @(negedge clk); i_irq_clr = 1'b1;
    @(negedge clk); i_irq_clr = 1'b0;
    rd_lat = rl; wr_lat = wl;
    obs.delete();
    timed_out = 1'b0; irq_cyc = 0; busy_at1 = 1'b0;
    i_start = 1'b1; i_src_addr = src; i_dst_addr = dst; i_total_len = len;
    c0 = cycle;
    for (int unsigned k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (k == 1) busy_at1 = o_busy;
      if (o_irq) begin irq_cyc = cycle; break; end
      i_start = (k == spur_at);
      if (k == spur_at) begin
        i_src_addr = 32'h100; i_dst_addr = 32'h200; i_total_len = 32'd4;
      end
      i_abort = (k == abort_at);
    end
    if (irq_cyc == 0) timed_out = 1'b1;
    i_start = 1'b0; i_abort = 1'b0;
  endtask

  task automatic test_reset;
    vectors++;
    if ({o_rd_start, o_wr_start, o_busy, o_irq, o_err_code, o_bytes_done, o_rd_src_addr,
         o_wr_dst_addr, o_rd_total_len, o_wr_total_len} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%0b irq=%0b err=%0d bytes=%0d required all zero",
               o_busy, o_irq, o_err_code, o_bytes_done);
    end
  endtask

  task automatic test_single;
    model(32'h4000, 32'h8000, 32'd64, 0);
    do_xfer(32'h4000, 32'h8000, 32'd64, 3, 5, 0, 0);
    vectors++;
    if (timed_out) begin miscompares++; $display("FAIL single_wait: irq never seen"); end
    vectors++;
    if (busy_at1 !== 1'b1) begin miscompares++; $display("FAIL single_busy_rise: got %0b required 1", busy_at1); end
    vectors++;
    if (obs.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d required 1", obs.size()); end
    if (obs.size() >= 1) begin
      vectors++;
      if ({obs[0].rd, obs[0].wr, obs[0].src, obs[0].dst, obs[0].rlen, obs[0].wlen} !==
          {2'b11, 32'h4000, 32'h8000, 32'd64, 32'd64}) begin
        miscompares++;
        $display("FAIL single_chunk: got rd=%0b wr=%0b src=%h dst=%h len=%0d/%0d required 4000/8000/64",
                 obs[0].rd, obs[0].wr, obs[0].src, obs[0].dst, obs[0].rlen, obs[0].wlen);
      end
      vectors++;
      if (obs[0].cyc - c0 != 2) begin miscompares++; $display("FAIL start_latency: got %0d required 2", obs[0].cyc - c0); end
    end
    vectors++;
    if (irq_cyc - last_done != 2) begin miscompares++; $display("FAIL irq_latency: got %0d required 2", irq_cyc - last_done); end
    vectors++;
    if ({o_irq, o_busy, o_err_code, o_bytes_done} !== {1'b1, 1'b1, exp_err, exp_bytes}) begin
      miscompares++;
      $display("FAIL single_status: got irq=%0b busy=%0b err=%0d bytes=%0d required 1 1 %0d %0d",
               o_irq, o_busy, o_err_code, o_bytes_done, exp_err, exp_bytes);
    end
    @(negedge clk);
    vectors++;
    if ({o_busy, o_irq} !== 2'b01) begin miscompares++; $display("FAIL busy_fall: got busy=%0b irq=%0b required 0 1", o_busy, o_irq); end
    i_irq_clr = 1'b1; @(negedge clk); i_irq_clr = 1'b0;
    vectors++;
    if ({o_irq, o_err_code} !== 4'b0) begin miscompares++; $display("FAIL irq_clr: got irq=%0b err=%0d required 0 0", o_irq, o_err_code); end
  endtask

  task automatic test_chunking;
    model(32'h4000, 32'h8000, 32'd10000, 0);
    do_xfer(32'h4000, 32'h8000, 32'd10000, 4, 2, 0, 0);
    vectors++;
    if (timed_out || obs.size() != exp_q.size()) begin
      miscompares++; $display("FAIL chunk_count: got %0d required %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if ({obs[i].rd, obs[i].wr, obs[i].src, obs[i].dst, obs[i].rlen, obs[i].wlen} !==
          {2'b11, exp_q[i].src, exp_q[i].dst, exp_q[i].len, exp_q[i].len}) begin
        miscompares++;
        $display("FAIL chunk%0d: got src=%h dst=%h len=%0d/%0d required src=%h dst=%h len=%0d",
                 i, obs[i].src, obs[i].dst, obs[i].rlen, obs[i].wlen, exp_q[i].src, exp_q[i].dst, exp_q[i].len);
      end
    end
    if (obs.size() == 3) begin
      vectors++;
      if ({obs[2].src, obs[2].rlen} !== {32'h6000, 32'd1808}) begin
        miscompares++; $display("FAIL tail_chunk: got %h/%0d required 6000/1808", obs[2].src, obs[2].rlen);
      end
    end
    vectors++;
    if ({o_err_code, o_bytes_done} !== {3'd0, 32'd10000}) begin
      miscompares++; $display("FAIL chunk_status: got err=%0d bytes=%0d required 0 10000", o_err_code, o_bytes_done);
    end
  endtask

  task automatic test_bad_desc;
    logic [31:0] tbl[4][3];
    tbl = '{'{32'h4002, 32'h8000, 32'd64}, '{32'h4000, 32'h8001, 32'd64},
            '{32'h4000, 32'h8000, 32'd66}, '{32'h4000, 32'h8000, 32'd0}};
    for (int t = 0; t < 4; t++) begin
      model(tbl[t][0], tbl[t][1], tbl[t][2], 0);
      do_xfer(tbl[t][0], tbl[t][1], tbl[t][2], 3, 3, 0, 0);
      vectors++;
      if (timed_out || obs.size() != 0 || irq_cyc - c0 != 2) begin
        miscompares++; $display("FAIL bad_desc%0d_flow: got starts=%0d irq_after=%0d required 0 2", t, obs.size(), irq_cyc - c0);
      end
      vectors++;
      if ({o_irq, o_err_code, o_bytes_done} !== {1'b1, exp_err, 32'd0}) begin
        miscompares++; $display("FAIL bad_desc%0d_err: got irq=%0b err=%0d bytes=%0d required 1 %0d 0", t, o_irq, o_err_code, o_bytes_done, exp_err);
      end
    end
  endtask

  task automatic test_done_order;
    int unsigned lat[3][2];
    int unsigned mx;
    lat = '{'{3, 7}, '{7, 3}, '{4, 4}};
    for (int t = 0; t < 3; t++) begin
      mx = (lat[t][0] > lat[t][1]) ? lat[t][0] : lat[t][1];
      do_xfer(32'h1_0000, 32'h2_0000, 32'd8192, lat[t][0], lat[t][1], 0, 0);
      vectors++;
      if (timed_out || obs.size() != 2) begin
        miscompares++; $display("FAIL order%0d_count: got %0d required 2", t, obs.size());
      end else begin
        vectors++;
        if (obs[1].cyc - obs[0].cyc != mx + 2 || obs[1].src !== 32'h1_1000) begin
          miscompares++; $display("FAIL order%0d_advance: got gap=%0d src=%h required %0d 00011000", t, obs[1].cyc - obs[0].cyc, obs[1].src, mx + 2);
        end
      end
      vectors++;
      if ({o_err_code, o_bytes_done} !== {3'd0, 32'd8192}) begin
        miscompares++; $display("FAIL order%0d_status: got err=%0d bytes=%0d required 0 8192", t, o_err_code, o_bytes_done);
      end
    end
  endtask

  task automatic test_timeout;
    do_xfer(32'h4000, 32'h8000, 32'd64, 0, 0, 0, 0);
    vectors++;
    if (timed_out || obs.size() != 1 || o_err_code !== 3'd3) begin
      miscompares++; $display("FAIL timeout_err: got starts=%0d err=%0d required 1 3", obs.size(), o_err_code);
    end else begin
      vectors++;
      if (irq_cyc - obs[0].cyc != TMO + 1) begin
        miscompares++; $display("FAIL timeout_cycles: got %0d required %0d", irq_cyc - obs[0].cyc, TMO + 1);
      end
    end
    // only the read side answers: its done restarts the timeout window
    do_xfer(32'h4000, 32'h8000, 32'd64, 5, 0, 0, 0);
    vectors++;
    if (timed_out || obs.size() != 1 || o_err_code !== 3'd3) begin
      miscompares++; $display("FAIL timeout_half_err: got starts=%0d err=%0d required 1 3", obs.size(), o_err_code);
    end else begin
      vectors++;
      if (irq_cyc - obs[0].cyc != TMO + 6) begin
        miscompares++; $display("FAIL timeout_restart: got %0d required %0d", irq_cyc - obs[0].cyc, TMO + 6);
      end
    end
  endtask

  task automatic test_abort;
    model(32'h4000, 32'h8000, 32'd12288, 1);
    do_xfer(32'h4000, 32'h8000, 32'd12288, 20, 20, 6, 0);
    vectors++;
    if (timed_out || obs.size() != exp_q.size()) begin
      miscompares++; $display("FAIL abort_count: got %0d required %0d", obs.size(), exp_q.size());
    end
    vectors++;
    if ({o_irq, o_err_code, o_bytes_done} !== {1'b1, exp_err, exp_bytes}) begin
      miscompares++; $display("FAIL abort_status: got irq=%0b err=%0d bytes=%0d required 1 %0d %0d", o_irq, o_err_code, o_bytes_done, exp_err, exp_bytes);
    end
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 2; t++) begin
      model(32'h3_0000 + 32'(t) * 32'h100, 32'h5_0000, 32'd8192, 0);
      do_xfer(32'h3_0000 + 32'(t) * 32'h100, 32'h5_0000, 32'd8192, 2, 3, 0, 4);
      vectors++;
      if (timed_out || obs.size() != exp_q.size()) begin
        miscompares++; $display("FAIL b2b%0d_count: got %0d required %0d", t, obs.size(), exp_q.size());
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        vectors++;
        if ({obs[i].src, obs[i].dst, obs[i].rlen} !== {exp_q[i].src, exp_q[i].dst, exp_q[i].len}) begin
          miscompares++; $display("FAIL b2b%0d_chunk%0d: got %h/%h/%0d required %h/%h/%0d", t, i,
                                  obs[i].src, obs[i].dst, obs[i].rlen, exp_q[i].src, exp_q[i].dst, exp_q[i].len);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    rd_lat = 10; wr_lat = 10;
    obs.delete();
    @(negedge clk);
    i_start = 1'b1; i_src_addr = 32'h4000; i_dst_addr = 32'h8000; i_total_len = 32'd8192;
    @(negedge clk); i_start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    vectors++;
    if ({o_rd_start, o_wr_start, o_busy, o_irq, o_err_code, o_bytes_done, o_rd_src_addr,
         o_wr_dst_addr, o_rd_total_len, o_wr_total_len} !== '0) begin
      miscompares++; $display("FAIL midrun_reset: got busy=%0b irq=%0b len=%0d required all zero", o_busy, o_irq, o_rd_total_len);
    end
    repeat (15) @(negedge clk);
    vectors++;
    if (obs.size() != 1 || {o_busy, o_irq, o_err_code, o_bytes_done} !== '0) begin
      miscompares++; $display("FAIL stray_done: got starts=%0d busy=%0b irq=%0b bytes=%0d required 1 0 0 0", obs.size(), o_busy, o_irq, o_bytes_done);
    end
  endtask

  task automatic test_random;
    logic [31:0] s, d, l;
    int unsigned rl, wl;
    for (int n = 0; n < 16; n++) begin
      s = $urandom & ~32'h3;
      d = $urandom & ~32'h3;
      l = $urandom_range(1, 3 * CHUNK + 64) & ~32'h3;
      case ($urandom_range(0, 9))
        0:       s[1:0] = 2'($urandom_range(1, 3));
        1:       l = 32'd0;
        2:       l[0] = 1'b1;
        default: ;
      endcase
      rl = $urandom_range(1, 6);
      wl = $urandom_range(1, 6);
      model(s, d, l, 0);
      do_xfer(s, d, l, rl, wl, 0, 0);
      vectors++;
      if (timed_out || obs.size() != exp_q.size()) begin
        miscompares++; $display("FAIL rnd%0d_count: got %0d required %0d (len=%0d)", n, obs.size(), exp_q.size(), l);
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        vectors++;
        if ({obs[i].rd, obs[i].wr, obs[i].src, obs[i].dst, obs[i].rlen, obs[i].wlen} !==
            {2'b11, exp_q[i].src, exp_q[i].dst, exp_q[i].len, exp_q[i].len}) begin
          miscompares++; $display("FAIL rnd%0d_chunk%0d: got %h/%h/%0d required %h/%h/%0d", n, i,
                                  obs[i].src, obs[i].dst, obs[i].rlen, exp_q[i].src, exp_q[i].dst, exp_q[i].len);
        end
      end
      vectors++;
      if ({o_irq, o_err_code, o_bytes_done} !== {1'b1, exp_err, exp_bytes}) begin
        miscompares++; $display("FAIL rnd%0d_status: got irq=%0b err=%0d bytes=%0d required 1 %0d %0d", n, o_irq, o_err_code, o_bytes_done, exp_err, exp_bytes);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    i_start = 1'b0; i_abort = 1'b0; i_irq_clr = 1'b0;
    i_src_addr = '0; i_dst_addr = '0; i_total_len = '0;
    rd_lat = 1; wr_lat = 1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_chunking();
    test_bad_desc();
    test_done_order();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
